// File: rtl/screen_pkg.sv
// Shared screen-manager types, defaults and the constant scene table.
// The scene sequencer's optional beat advance is enabled by SCENE_BEAT_ADVANCE_EN.
package screen_pkg;

  localparam int DEF_NUM_SCENES = 8;
  localparam int DEF_LAYERS = 64;
  localparam int DEF_DUR_W = 8;
  localparam int DEF_IDX_W = $clog2(DEF_NUM_SCENES);
  localparam logic [10:0] DEF_BEAT_THRESH = 11'd512;
  localparam int DEF_BEAT_FRAMES = 3;

  typedef struct packed {
    logic [DEF_LAYERS-1:0] mask;
    logic                  motion;
    logic [DEF_DUR_W-1:0]  dur;
  } scene_t;

  localparam scene_t SCENE_TABLE [DEF_NUM_SCENES] = '{
    '{64'h0000_0000_0000_000F, 1'b0, 8'd4},
    '{64'h0000_0000_0000_00F0, 1'b1, 8'd0},
    '{64'h0000_0000_0000_0F00, 1'b0, 8'd2},
    '{64'h0000_0000_0000_F000, 1'b1, 8'd3},
    '{64'h0000_0000_000F_0000, 1'b0, 8'd1},
    '{64'h0000_0000_00F0_0000, 1'b1, 8'd3},
    '{64'h0000_0000_0F00_0000, 1'b0, 8'd10},
    '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'd2}
  };

  // A zero duration still shows the scene for one frame.
  function automatic logic [DEF_DUR_W-1:0] dur_eff(
    input logic [DEF_DUR_W-1:0] d
  );
    return (d == '0) ? DEF_DUR_W'(1) : d;
  endfunction

endpackage

// File: rtl/scene_sequencer_if.sv
// Control and output bundle of the scene sequencer.
// Master drives timing/control, slave is the sequencer.
interface scene_sequencer_if;
  import screen_pkg::*;

  logic [9:0]            iVGA_X;
  logic [8:0]            iVGA_Y;
  logic                  iRun;
  logic                  iHold;
  logic                  iSkip;
  logic [DEF_LAYERS-1:0] iManualMask;
  logic [10:0]           iPower;
  logic [DEF_LAYERS-1:0] oLayerEn;
  logic                  oMotionEn;
  logic [DEF_IDX_W-1:0]  oSceneIdx;
  logic                  oFrameTick;

  modport master (
    output iVGA_X, iVGA_Y,
    output iRun, iHold, iSkip,
    output iManualMask, iPower,
    input  oLayerEn, oMotionEn,
    input  oSceneIdx, oFrameTick
  );

  modport slave (
    input  iVGA_X, iVGA_Y,
    input  iRun, iHold, iSkip,
    input  iManualMask, iPower,
    output oLayerEn, oMotionEn,
    output oSceneIdx, oFrameTick
  );

endinterface

// File: rtl/scene_sequencer_frame_tick_gen.sv
// Frame origin detector: registers the origin flag and edge-detects it.
// rise is the early strobe, tick the registered one-cycle pulse.
module frame_tick_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic       rise,
  output logic       tick
);

  logic org_q;
  logic org_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      org_q <= 1'b0;
      org_d <= 1'b0;
      tick  <= 1'b0;
    end else begin
      org_q <= (x == '0) && (y == '0);
      org_d <= org_q;
      tick  <= rise;
    end
  end

  assign rise = org_q & ~org_d;

endmodule

// File: rtl/scene_sequencer.sv
// Frame-synchronous scene sequencer for the 64-layer compositor.
// Beat-driven advance is built only with SCENE_BEAT_ADVANCE_EN defined.
module scene_sequencer
  import screen_pkg::*;
#(
  parameter int          NUM_SCENES  = DEF_NUM_SCENES,
  parameter int          LAYERS      = DEF_LAYERS,
  parameter int          DUR_W       = DEF_DUR_W,
  parameter logic [10:0] BEAT_THRESH = DEF_BEAT_THRESH,
  parameter int          BEAT_FRAMES = DEF_BEAT_FRAMES
) (
  input logic              clk,
  input logic              reset,
  scene_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_SCENES);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n, idx_inc;
  logic [DUR_W-1:0]  cnt, cnt_n, cnt_sat;
  logic [DUR_W-1:0]  dur_q, dur_n;
  logic [DUR_W:0]    cnt_p1;
  logic [LAYERS-1:0] mask, mask_n;
  logic              motion, motion_n;
  logic              skip_pend, skip_n;
  logic              rise, tick;
  logic              expire, beat, adv;
  scene_t            nxt;

  frame_tick_gen u_tick (
    .clk   (clk),
    .reset (reset),
    .x     (bus.iVGA_X),
    .y     (bus.iVGA_Y),
    .rise  (rise),
    .tick  (tick)
  );

`ifdef SCENE_BEAT_ADVANCE_EN
  localparam int BW = $clog2(BEAT_FRAMES + 1);

  logic [BW-1:0] bcnt, bcnt_n, bcnt_p1;
  logic          pwr_hi;

  always_ff @(posedge clk) begin
    if (reset) bcnt <= '0;
    else       bcnt <= bcnt_n;
  end

  // Beats only count on HOLD ticks; a fresh scene ignores them for two frames.
  always_comb begin
    bcnt_n  = bcnt;
    beat    = 1'b0;
    pwr_hi  = bus.iPower >= BEAT_THRESH;
    bcnt_p1 = bcnt + 1'b1;
    if (rise && bus.iRun && state == HOLD) begin
      if (!pwr_hi) begin
        bcnt_n = '0;
      end else if (bcnt_p1 >= BW'(BEAT_FRAMES)) begin
        bcnt_n = '0;
        beat   = cnt >= DUR_W'(2);
      end else begin
        bcnt_n = bcnt_p1;
      end
    end else if (rise) begin
      bcnt_n = '0;
    end
  end
`else
  assign beat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      dur_q     <= '0;
      mask      <= '0;
      motion    <= 1'b0;
      skip_pend <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      dur_q     <= dur_n;
      mask      <= mask_n;
      motion    <= motion_n;
      skip_pend <= skip_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    dur_n    = dur_q;
    mask_n   = mask;
    motion_n = motion;
    skip_n   = skip_pend | bus.iSkip;
    adv      = 1'b0;
    idx_inc  = (idx == IDX_W'(NUM_SCENES - 1)) ? '0 : idx + 1'b1;
    cnt_p1   = {1'b0, cnt} + (DUR_W + 1)'(1);
    cnt_sat  = (&cnt) ? cnt : cnt + 1'b1;
    expire   = cnt_p1 >= {1'b0, dur_eff(dur_q)};
    nxt      = SCENE_TABLE[idx_inc];
    if (rise) begin
      // A skip arriving on the tick itself is kept for the next tick.
      skip_n = bus.iSkip;
      unique case (1'b1)
        !bus.iRun: begin
          state_n  = IDLE;
          mask_n   = bus.iManualMask;
          motion_n = 1'b0;
        end
        bus.iRun && state == IDLE: begin
          state_n  = HOLD;
          idx_n    = '0;
          mask_n   = SCENE_TABLE[0].mask;
          motion_n = SCENE_TABLE[0].motion;
          dur_n    = SCENE_TABLE[0].dur;
          cnt_n    = '0;
        end
        bus.iRun && state == HOLD: begin
          adv = skip_pend | (expire & ~bus.iHold) | beat;
          if (adv) begin
            idx_n    = idx_inc;
            mask_n   = nxt.mask;
            motion_n = nxt.motion;
            dur_n    = nxt.dur;
            cnt_n    = '0;
          end else if (!bus.iHold) begin
            cnt_n = cnt_sat;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.oLayerEn   = mask;
  assign bus.oMotionEn  = motion;
  assign bus.oSceneIdx  = idx;
  assign bus.oFrameTick = tick;

endmodule
